// File: rtl/integral_box_sum_sched_if.sv
// -----------------------------------------------------------------------------
// integral_box_sum_sched_if
// Bundles the three channels of the box-sum query scheduler:
//   - query request: req_valid/req_ready with an inclusive rectangle
//     (req_x0, req_y0, req_x1, req_y1), plus frame_ready from the integral
//     compute block
//   - shared integral M10K read port: mem_rd_req/mem_rd_gnt/mem_rd_addr/
//     mem_rd_data
//   - response: rsp_valid/rsp_ready carrying rsp_sum and rsp_err
// Modports:
//   slave  - the scheduler (serves queries and drives the read request)
//   master - the surrounding system (requesters, memory mux, consumer)
// -----------------------------------------------------------------------------
interface integral_box_sum_sched_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 25
);
   logic              req_valid;
   logic              req_ready;
   logic [8:0]        req_x0;
   logic [7:0]        req_y0;
   logic [8:0]        req_x1;
   logic [7:0]        req_y1;
   logic              frame_ready;
   logic              mem_rd_req;
   logic              mem_rd_gnt;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_sum;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_x0, req_y0, req_x1, req_y1, frame_ready,
      input  mem_rd_gnt, mem_rd_data, rsp_ready,
      output req_ready, mem_rd_req, mem_rd_addr, rsp_valid, rsp_sum, rsp_err
   );

   modport master (
      output req_valid, req_x0, req_y0, req_x1, req_y1, frame_ready,
      output mem_rd_gnt, mem_rd_data, rsp_ready,
      input  req_ready, mem_rd_req, mem_rd_addr, rsp_valid, rsp_sum, rsp_err
   );
endinterface

// File: rtl/integral_box_sum_sched.sv
// -----------------------------------------------------------------------------
// integral_box_sum_sched
// Rectangle-sum query scheduler for a shared integral-image M10K read port.
// Accepts one inclusive rectangle, validates it, issues up to four corner reads
// (D, B, C, A) through a request/grant port that may stall, accumulates
// D - B - C + A as the data returns, and presents the sum (or an error) on a
// valid/ready response channel.
// Ports:
//   clk_50 - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - integral_box_sum_sched_if.slave (query, read port, response)
// -----------------------------------------------------------------------------
module integral_box_sum_sched #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 25,
   parameter int READ_LAT   = 2
) (
   input  logic                          clk_50,
   input  logic                          reset,
   integral_box_sum_sched_if.slave       bus
);

   localparam int         ACC_W = DATA_W + 2;
   localparam logic [8:0] X_LIM = 9'(IMG_WIDTH);
   localparam logic [7:0] Y_LIM = 8'(IMG_HEIGHT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t                   state_r;
   logic [8:0]               x0_r, x1_r;
   logic [7:0]               y0_r, y1_r;
   logic [ADDR_W-1:0]        addr_q_r [4];
   logic [2:0]               n_r;
   logic [2:0]               idx_r;
   logic [2:0]               ret_cnt_r;
   logic [READ_LAT-1:0]      tag_v_r;
   logic [READ_LAT-1:0]      tag_n_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic                     stale_r;
   logic                     ready_r;
   logic                     rd_req_r;
   logic [ADDR_W-1:0]        rd_addr_r;
   logic                     rsp_valid_r;
   logic [DATA_W-1:0]        rsp_sum_r;
   logic                     rsp_err_r;

   logic                     arrive_s;
   logic signed [ACC_W-1:0]  data_ext_s;
   logic signed [ACC_W-1:0]  acc_next_s;
   logic [2:0]               ret_next_s;
   logic [2:0]               idx_inc_s;
   logic                     fire_s;
   logic                     fire_neg_s;
   logic                     stale_next_s;
   logic                     check_err_s;
   logic [ADDR_W-1:0]        addr_d_s, addr_b_s, addr_c_s, addr_a_s;

   // Row-major integral address of a corner.
   function automatic logic [ADDR_W-1:0] corner_addr(input logic [8:0] x, input logic [7:0] y);
      corner_addr = ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
   endfunction

   // req_ready is forced low while reset is held so it is 0 during reset and
   // 1 in the very first cycle after it.
   assign bus.req_ready   = ready_r & ~reset;
   assign bus.mem_rd_req  = rd_req_r;
   assign bus.mem_rd_addr = rd_addr_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_sum     = rsp_sum_r;
   assign bus.rsp_err     = rsp_err_r;

   assign arrive_s     = tag_v_r[READ_LAT-1];
   assign data_ext_s   = $signed({2'b00, bus.mem_rd_data});
   assign ret_next_s   = ret_cnt_r + {2'b00, arrive_s};
   assign idx_inc_s    = idx_r + 3'd1;
   assign fire_s       = (state_r == S_ISSUE) && bus.mem_rd_gnt;
   // Corner list slots are always ordered D,B|C,C,A so the sign follows the slot.
   assign fire_neg_s   = (idx_r == 3'd1) || (idx_r == 3'd2);
   assign stale_next_s = stale_r | (((state_r == S_ISSUE) || (state_r == S_WAIT)) && !bus.frame_ready);
   assign check_err_s  = (x1_r < x0_r) || (y1_r < y0_r) || (x1_r >= X_LIM) ||
                         (y1_r >= Y_LIM) || !bus.frame_ready;

   assign addr_d_s = corner_addr(x1_r, y1_r);
   assign addr_b_s = corner_addr(x0_r - 9'd1, y1_r);
   assign addr_c_s = corner_addr(x1_r, y0_r - 8'd1);
   assign addr_a_s = corner_addr(x0_r - 9'd1, y0_r - 8'd1);

   // Signed accumulation of the returning corner word.
   always_comb begin
      acc_next_s = acc_r;
      if (arrive_s) begin
         if (tag_n_r[READ_LAT-1]) begin
            acc_next_s = acc_r - data_ext_s;
         end else begin
            acc_next_s = acc_r + data_ext_s;
         end
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Query FSM, read issue, return-tag pipeline and registered outputs.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_r     <= S_IDLE;
         x0_r        <= 9'd0;
         x1_r        <= 9'd0;
         y0_r        <= 8'd0;
         y1_r        <= 8'd0;
         for (int i = 0; i < 4; i++) addr_q_r[i] <= '0;
         n_r         <= 3'd0;
         idx_r       <= 3'd0;
         ret_cnt_r   <= 3'd0;
         tag_v_r     <= '0;
         tag_n_r     <= '0;
         acc_r       <= '0;
         stale_r     <= 1'b0;
         ready_r     <= 1'b1;
         rd_req_r    <= 1'b0;
         rd_addr_r   <= '0;
         rsp_valid_r <= 1'b0;
         rsp_sum_r   <= '0;
         rsp_err_r   <= 1'b0;
      end else begin
         tag_v_r[0] <= fire_s;
         tag_n_r[0] <= fire_neg_s;
         for (int k = 1; k < READ_LAT; k++) begin
            tag_v_r[k] <= tag_v_r[k-1];
            tag_n_r[k] <= tag_n_r[k-1];
         end
         acc_r     <= acc_next_s;
         ret_cnt_r <= ret_next_s;
         stale_r   <= stale_next_s;

         case (state_r)
            S_IDLE: begin
               if (bus.req_valid) begin
                  x0_r    <= bus.req_x0;
                  y0_r    <= bus.req_y0;
                  x1_r    <= bus.req_x1;
                  y1_r    <= bus.req_y1;
                  ready_r <= 1'b0;
                  state_r <= S_CHECK;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            S_CHECK: begin
               acc_r     <= '0;
               ret_cnt_r <= 3'd0;
               stale_r   <= 1'b0;
               idx_r     <= 3'd0;
               if (check_err_s) begin
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b1;
                  rsp_sum_r   <= '0;
                  state_r     <= S_RESP;
               end else begin
                  addr_q_r[0] <= addr_d_s;
                  if ((x0_r != 9'd0) && (y0_r != 8'd0)) begin
                     addr_q_r[1] <= addr_b_s;
                     addr_q_r[2] <= addr_c_s;
                     addr_q_r[3] <= addr_a_s;
                     n_r         <= 3'd4;
                  end else if (x0_r != 9'd0) begin
                     addr_q_r[1] <= addr_b_s;
                     n_r         <= 3'd2;
                  end else if (y0_r != 8'd0) begin
                     addr_q_r[1] <= addr_c_s;
                     n_r         <= 3'd2;
                  end else begin
                     n_r         <= 3'd1;
                  end
                  rd_req_r  <= 1'b1;
                  rd_addr_r <= addr_d_s;
                  state_r   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.mem_rd_gnt) begin
                  idx_r <= idx_inc_s;
                  if (idx_inc_s == n_r) begin
                     rd_req_r <= 1'b0;
                     state_r  <= S_WAIT;
                  end else begin
                     rd_addr_r <= addr_q_r[idx_inc_s[1:0]];
                  end
               end else begin
                  rd_req_r <= 1'b1;
               end
            end
            S_WAIT: begin
               if (ret_next_s == n_r) begin
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= stale_next_s;
                  rsp_sum_r   <= stale_next_s ? '0 : acc_next_s[DATA_W-1:0];
                  state_r     <= S_RESP;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  ready_r     <= 1'b1;
                  state_r     <= S_IDLE;
               end else begin
                  rsp_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_integral_box_sum_sched.sv
// -----------------------------------------------------------------------------
// tb_integral_box_sum_sched
// Directed bench for integral_box_sum_sched on an 8x8 all-ones image, so the
// integral word at (x,y) is (x+1)*(y+1). A behavioural two-cycle read port
// logs every granted address; expected responses go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_integral_box_sum_sched;

   localparam int W = 8;
   localparam int H = 8;

   typedef struct {
      int sum;
      bit err;
   } rsp_t;

   logic clk_50 = 1'b0;
   logic reset  = 1'b1;
   int   tests  = 0;
   int   fails  = 0;
   rsp_t sb[$];
   int   addr_log[$];
   logic [16:0] pa0;

   integral_box_sum_sched_if #(.ADDR_W(17), .DATA_W(25)) bus ();

   integral_box_sum_sched #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .ADDR_W    (17),
      .DATA_W    (25),
      .READ_LAT  (2)
   ) dut (
      .clk_50(clk_50),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk_50 = ~clk_50;

   function automatic int img(input int a);
      return ((a % W) + 1) * ((a / W) + 1);
   endfunction

   // Read port model: data valid two cycles after a granted address.
   always @(posedge clk_50) begin
      pa0 <= bus.mem_rd_addr;
      bus.mem_rd_data <= 25'(img(int'(pa0)));
      if (bus.mem_rd_req && bus.mem_rd_gnt) addr_log.push_back(int'(bus.mem_rd_addr));
   end

   task automatic cyc();
      @(posedge clk_50);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One query: gpat[i] is the grant in cycle 2+i, hold = rsp_ready-low cycles,
   // drop_at = cycle in which frame_ready falls (-1 = never), fr0 = frame_ready
   // at acceptance.
   task automatic run_q(input int x0, input int y0, input int x1, input int y1,
                        input int exp_sum, input bit exp_err, input int exp_lat,
                        input logic [6:0] gpat, input int hold, input int drop_at,
                        input bit fr0);
      int   cnt;
      int   exp_addr[$];
      rsp_t r;
      bit   bad;
      bad = (x1 < x0) || (y1 < y0) || (x1 >= W) || (y1 >= H) || !fr0;
      if (!bad) begin
         exp_addr.push_back(y1 * W + x1);
         if (x0 > 0) exp_addr.push_back(y1 * W + x0 - 1);
         if (y0 > 0) exp_addr.push_back((y0 - 1) * W + x1);
         if (x0 > 0 && y0 > 0) exp_addr.push_back((y0 - 1) * W + x0 - 1);
      end
      addr_log.delete();
      sb.push_back('{exp_sum, exp_err});
      bus.frame_ready = fr0;
      bus.rsp_ready   = (hold == 0);
      bus.mem_rd_gnt  = 1'b1;
      chk("req_ready_idle", int'(bus.req_ready), 1);
      bus.req_x0 = 9'(x0);
      bus.req_y0 = 8'(y0);
      bus.req_x1 = 9'(x1);
      bus.req_y1 = 8'(y1);
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      cnt = 1;
      while (!bus.rsp_valid && cnt < 40) begin
         cyc();
         cnt++;
         bus.mem_rd_gnt = (cnt >= 2 && cnt <= 8) ? gpat[cnt-2] : 1'b1;
         if (cnt == drop_at) bus.frame_ready = 1'b0;
      end
      bus.mem_rd_gnt = 1'b1;
      chk("rsp_valid", int'(bus.rsp_valid), 1);
      r = sb.pop_front();
      if (bus.rsp_valid) begin
         chk("latency", cnt, exp_lat);
         chk("rsp_sum", int'(bus.rsp_sum), r.sum);
         chk("rsp_err", int'(bus.rsp_err), int'(r.err));
         for (int i = 0; i < hold; i++) begin
            cyc();
            chk("hold_valid", int'(bus.rsp_valid), 1);
            chk("hold_sum", int'(bus.rsp_sum), r.sum);
            chk("hold_err", int'(bus.rsp_err), int'(r.err));
            chk("hold_req_ready", int'(bus.req_ready), 0);
         end
         bus.rsp_ready = 1'b1;
      end
      cyc();
      chk("rsp_valid_drop", int'(bus.rsp_valid), 0);
      chk("req_ready_back", int'(bus.req_ready), 1);
      chk("n_reads", addr_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
         chk("read_addr", addr_log[i], exp_addr[i]);
      bus.frame_ready = 1'b1;
   endtask

   initial begin
      int  cnt;
      bit  seen;
      bus.req_valid   = 1'b0;
      bus.req_x0      = 9'd0;
      bus.req_y0      = 8'd0;
      bus.req_x1      = 9'd0;
      bus.req_y1      = 8'd0;
      bus.frame_ready = 1'b1;
      bus.mem_rd_gnt  = 1'b1;
      bus.rsp_ready   = 1'b1;

      // Reset state.
      cyc();
      cyc();
      chk("rst_req_ready", int'(bus.req_ready), 0);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_mem_rd_req", int'(bus.mem_rd_req), 0);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", int'(bus.req_ready), 1);
      chk("post_rst_addr", int'(bus.mem_rd_addr), 0);
      chk("post_rst_sum", int'(bus.rsp_sum), 0);
      chk("post_rst_err", int'(bus.rsp_err), 0);
      cyc();

      // Main function.
      run_q(2, 3, 5, 6, 16, 1'b0, 8, 7'b1111111, 0, -1, 1'b1);
      run_q(0, 0, 7, 7, 64, 1'b0, 5, 7'b1111111, 0, -1, 1'b1);
      run_q(0, 2, 3, 4, 12, 1'b0, 6, 7'b1111111, 0, -1, 1'b1);
      run_q(3, 0, 4, 1,  4, 1'b0, 6, 7'b1111111, 0, -1, 1'b1);
      run_q(2, 3, 5, 6, 16, 1'b0, 11, 7'b1011001, 0, -1, 1'b1);
      // Error cases.
      run_q(2, 3, 8, 6, 0, 1'b1, 2, 7'b1111111, 0, -1, 1'b1);
      run_q(5, 3, 2, 6, 0, 1'b1, 2, 7'b1111111, 0, -1, 1'b1);
      run_q(2, 3, 5, 6, 0, 1'b1, 2, 7'b1111111, 0, -1, 1'b0);
      // Stale frame during WAIT.
      run_q(2, 3, 5, 6, 0, 1'b1, 8, 7'b1111111, 0, 6, 1'b1);
      // Back-pressure on the response.
      run_q(1, 1, 6, 5, 30, 1'b0, 8, 7'b1111111, 5, -1, 1'b1);

      // Reset while in WAIT: the query is dropped.
      addr_log.delete();
      bus.req_x0 = 9'd2;
      bus.req_y0 = 8'd3;
      bus.req_x1 = 9'd5;
      bus.req_y1 = 8'd6;
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
      for (cnt = 1; cnt < 6; cnt++) cyc();
      reset = 1'b1;
      cyc();
      chk("wait_rst_req_ready", int'(bus.req_ready), 0);
      chk("wait_rst_rsp_valid", int'(bus.rsp_valid), 0);
      cyc();
      reset = 1'b0;
      #1;
      chk("wait_rst_ready_after", int'(bus.req_ready), 1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         seen = seen | bus.rsp_valid;
      end
      chk("wait_rst_no_rsp", int'(seen), 0);
      run_q(2, 3, 5, 6, 16, 1'b0, 8, 7'b1111111, 0, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
